// File: rtl/common.sv
// Shared types for the execute-side pipeline: data words, ALU opcodes,
// register indices and the operand-stage state encoding.
package common;
    localparam int DATA_W             = 32;
    localparam int IMEM_ADDR_W        = 32;
    localparam int DEFAULT_REG_ADDR_W = 5;

    typedef logic [DATA_W-1:0]             data_t;
    typedef logic [IMEM_ADDR_W-1:0]        instruction_memory_address_t;
    typedef logic [DEFAULT_REG_ADDR_W-1:0] reg_addr_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLL  = 4'd6,
        ALU_SRL  = 4'd7,
        ALU_SRA  = 4'd8,
        ALU_ADDI = 4'd9,
        ALU_LUI  = 4'd10
    } alu_instruction_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2
    } operand_state_t;
endpackage

// File: rtl/operand_bypass_mux.sv
// Per-operand source select: forced zero, then live writeback, then the
// writeback seen at accept time, then the register-file read data.
module operand_bypass_mux
    import common::*;
(
    input  logic  force_zero_i,
    input  logic  wb_hit_i,
    input  data_t wb_data_i,
    input  logic  pend_valid_i,
    input  data_t pend_data_i,
    input  data_t rf_data_i,
    output data_t operand_o
);
    always_comb begin
        operand_o = rf_data_i;
        if (force_zero_i) begin
            operand_o = '0;
        end else if (wb_hit_i) begin
            operand_o = wb_data_i;
        end else if (pend_valid_i) begin
            operand_o = pend_data_i;
        end
    end
endmodule

// File: rtl/alu_operand_stage.sv
// Operand-fetch stage ahead of the ALU: reads rs1/rs2 from the synchronous RF,
// applies writeback bypass, and holds a registered bundle under valid/ready.
module alu_operand_stage
    import common::*;
#(
    parameter int NUM_REGS   = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  instruction_memory_address_t in_pc,
    input  alu_instruction_t            in_instr,
    input  logic [REG_ADDR_W-1:0]       in_rs1,
    input  logic [REG_ADDR_W-1:0]       in_rs2,
    input  logic [REG_ADDR_W-1:0]       in_rd,
    input  logic                        in_uses_rs2,
    input  data_t                       in_imm,
    output logic [REG_ADDR_W-1:0]       rf_rd_addr1,
    output logic [REG_ADDR_W-1:0]       rf_rd_addr2,
    input  data_t                       rf_rd_data1,
    input  data_t                       rf_rd_data2,
    input  logic                        wb_valid,
    input  logic [REG_ADDR_W-1:0]       wb_rd,
    input  data_t                       wb_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output instruction_memory_address_t out_pc,
    output alu_instruction_t            out_instr,
    output data_t                       out_op1,
    output data_t                       out_op2,
    output data_t                       out_imm,
    output logic [REG_ADDR_W-1:0]       out_rd
);
    if (REG_ADDR_W != $clog2(NUM_REGS)) begin : g_bad_cfg
        $error("REG_ADDR_W must equal clog2(NUM_REGS)");
    end

    operand_state_t              state_q, state_d;
    logic                        accept, capture, hold;
    instruction_memory_address_t pc_q, out_pc_q;
    alu_instruction_t            instr_q, out_instr_q;
    data_t                       imm_q, out_imm_q;
    logic [REG_ADDR_W-1:0]       rd_q, out_rd_q;
    logic                        uses_rs2_q;
    logic [REG_ADDR_W-1:0]       rs_q [2];
    logic [REG_ADDR_W-1:0]       in_rs [2];
    logic [1:0]                  pend_q;
    data_t                       pend_data_q [2];
    data_t                       rf_data [2];
    data_t                       fetch_op [2];
    data_t                       out_op_q [2];
    logic [1:0]                  in_hit, hold_hit;

    assign in_ready    = ((state_q == IDLE) || ((state_q == VALID) && out_ready)) && rst_n;
    assign accept      = in_valid && in_ready;
    assign out_valid   = (state_q == VALID);
    assign rf_rd_addr1 = in_rs1;
    assign rf_rd_addr2 = in_rs2;
    assign in_rs[0]    = in_rs1;
    assign in_rs[1]    = in_rs2;
    assign rf_data[0]  = rf_rd_data1;
    assign rf_data[1]  = rf_rd_data2;

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        hold    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) state_d = FETCH;
            end
            FETCH: begin
                state_d = VALID;
                capture = 1'b1;
            end
            VALID: begin
                if (out_ready) begin
                    state_d = accept ? FETCH : IDLE;
                end else begin
                    hold = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_op
        logic zero, live_hit;
        assign zero         = (rs_q[gi] == '0) || ((gi == 1) && !uses_rs2_q);
        assign live_hit     = wb_valid && (wb_rd == rs_q[gi]);
        // The RF returns the old value when written in the accept cycle.
        assign in_hit[gi]   = wb_valid && (wb_rd != '0) && (wb_rd == in_rs[gi]);
        assign hold_hit[gi] = hold && live_hit && !zero;

        operand_bypass_mux u_mux (
            .force_zero_i (zero),
            .wb_hit_i     (live_hit),
            .wb_data_i    (wb_data),
            .pend_valid_i (pend_q[gi]),
            .pend_data_i  (pend_data_q[gi]),
            .rf_data_i    (rf_data[gi]),
            .operand_o    (fetch_op[gi])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            instr_q     <= ALU_ADD;
            imm_q       <= '0;
            rd_q        <= '0;
            uses_rs2_q  <= 1'b0;
            pend_q      <= '0;
            out_pc_q    <= '0;
            out_instr_q <= ALU_ADD;
            out_imm_q   <= '0;
            out_rd_q    <= '0;
            for (int i = 0; i < 2; i++) begin
                rs_q[i]        <= '0;
                pend_data_q[i] <= '0;
                out_op_q[i]    <= '0;
            end
        end else begin
            state_q <= state_d;
            if (accept) begin
                pc_q       <= in_pc;
                instr_q    <= in_instr;
                imm_q      <= in_imm;
                rd_q       <= in_rd;
                uses_rs2_q <= in_uses_rs2;
                pend_q     <= in_hit;
                for (int i = 0; i < 2; i++) begin
                    rs_q[i]        <= in_rs[i];
                    pend_data_q[i] <= wb_data;
                end
            end
            if (capture) begin
                out_pc_q    <= pc_q;
                out_instr_q <= instr_q;
                out_imm_q   <= imm_q;
                out_rd_q    <= rd_q;
            end
            for (int i = 0; i < 2; i++) begin
                if (capture) begin
                    out_op_q[i] <= fetch_op[i];
                end else if (hold_hit[i]) begin
                    out_op_q[i] <= wb_data;
                end
            end
        end
    end

    assign out_pc    = out_pc_q;
    assign out_instr = out_instr_q;
    assign out_op1   = out_op_q[0];
    assign out_op2   = out_op_q[1];
    assign out_imm   = out_imm_q;
    assign out_rd    = out_rd_q;
endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage with a synchronous-read RF model
// and a queue of expected bundles pushed at accept time.
module tb_alu_operand_stage;
    import common::*;

    typedef struct packed {
        instruction_memory_address_t pc;
        alu_instruction_t            instr;
        data_t                       op1;
        data_t                       op2;
        data_t                       imm;
        reg_addr_t                   rd;
    } bundle_t;

    logic                        clk;
    logic                        rst_n;
    logic                        in_valid;
    logic                        in_ready;
    instruction_memory_address_t in_pc;
    alu_instruction_t            in_instr;
    reg_addr_t                   in_rs1, in_rs2, in_rd;
    logic                        in_uses_rs2;
    data_t                       in_imm;
    reg_addr_t                   rf_rd_addr1, rf_rd_addr2;
    data_t                       rf_rd_data1, rf_rd_data2;
    logic                        wb_valid;
    reg_addr_t                   wb_rd;
    data_t                       wb_data;
    logic                        out_valid;
    logic                        out_ready;
    instruction_memory_address_t out_pc;
    alu_instruction_t            out_instr;
    data_t                       out_op1, out_op2, out_imm;
    reg_addr_t                   out_rd;

    int      vectors;
    int      miscompares;
    bundle_t exp_q [$];
    bundle_t got;
    bundle_t obs;
    data_t   rf [32];

    assign obs = {out_pc, out_instr, out_op1, out_op2, out_imm, out_rd};

    alu_operand_stage #(.NUM_REGS(32), .REG_ADDR_W(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pc       (in_pc),
        .in_instr    (in_instr),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_rd       (in_rd),
        .in_uses_rs2 (in_uses_rs2),
        .in_imm      (in_imm),
        .rf_rd_addr1 (rf_rd_addr1),
        .rf_rd_addr2 (rf_rd_addr2),
        .rf_rd_data1 (rf_rd_data1),
        .rf_rd_data2 (rf_rd_data2),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_instr   (out_instr),
        .out_op1     (out_op1),
        .out_op2     (out_op2),
        .out_imm     (out_imm),
        .out_rd      (out_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read RF: a same-edge write is not visible to the read.
    always @(posedge clk) begin
        rf_rd_data1 <= rf[rf_rd_addr1];
        rf_rd_data2 <= rf[rf_rd_addr2];
        if (wb_valid && wb_rd != 5'd0) rf[wb_rd] <= wb_data;
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic set_wb(input logic v, input reg_addr_t rd, input data_t d);
        wb_valid = v;
        wb_rd    = rd;
        wb_data  = d;
    endtask

    task automatic drive_in(input instruction_memory_address_t pc, input alu_instruction_t instr,
                            input reg_addr_t rs1, input reg_addr_t rs2, input reg_addr_t rd,
                            input logic uses, input data_t imm);
        in_valid    = 1'b1;
        in_pc       = pc;
        in_instr    = instr;
        in_rs1      = rs1;
        in_rs2      = rs2;
        in_rd       = rd;
        in_uses_rs2 = uses;
        in_imm      = imm;
    endtask

    function automatic bundle_t mk(input instruction_memory_address_t pc, input alu_instruction_t instr,
                                   input data_t op1, input data_t op2, input data_t imm, input reg_addr_t rd);
        bundle_t b;
        b.pc = pc; b.instr = instr; b.op1 = op1; b.op2 = op2; b.imm = imm; b.rd = rd;
        return b;
    endfunction

    task automatic test_reset;
        reg_addr_t idx [5] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7};
        data_t     val [5] = '{32'd10, 32'd20, 32'h55aa, 32'd7, 32'hdeadbeef};
        rst_n = 1'b0;
        repeat (2) tick();
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hs: actual valid=%b ready=%b required 0 0", out_valid, in_ready);
        end
        vectors++;
        if (obs !== '0) begin
            miscompares++;
            $display("FAIL reset_bundle: actual %h required 0", obs);
        end
        rst_n = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_ready: actual %b required 1", in_ready);
        end
        for (int i = 0; i < 5; i++) begin
            set_wb(1'b1, idx[i], val[i]);
            tick();
        end
        set_wb(1'b0, 5'd0, 32'd0);
    endtask

    task automatic test_basic;
        drive_in(32'h100, ALU_ADD, 5'd3, 5'd4, 5'd5, 1'b1, 32'd0);
        exp_q.push_back(mk(32'h100, ALU_ADD, 32'd10, 32'd20, 32'd0, 5'd5));
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_idle_ready: actual %b required 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        vectors++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_fetch: actual ready=%b valid=%b required 0 0", in_ready, out_valid);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_latency: actual valid=%b required 1", out_valid);
        end
        got = exp_q.pop_front();
        vectors++;
        if (obs !== got) begin
            miscompares++;
            $display("FAIL basic_bundle: actual %h required %h", obs, got);
        end
        $display("txn basic pc=%h op1=%h op2=%h imm=%h rd=%0d", out_pc, out_op1, out_op2, out_imm, out_rd);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_after_hs: actual valid=%b ready=%b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_bypass;
        for (int k = 0; k < 3; k++) begin
            drive_in(32'h200 + k, ALU_SUB, 5'd3, 5'd4, 5'd8, 1'b1, 32'h10);
            exp_q.push_back(mk(32'h200 + k, ALU_SUB, 32'd99, 32'd20, 32'h10, 5'd8));
            set_wb(k == 0, 5'd3, 32'd99);
            tick();
            in_valid = 1'b0;
            set_wb(k == 1, 5'd3, 32'd99);
            tick();
            set_wb(1'b0, 5'd0, 32'd0);
            vectors++;
            if (out_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL bypass%0d_valid: actual %b required 1", k, out_valid);
            end
            if (k == 2) begin
                vectors++;
                if (out_op1 !== 32'd10) begin
                    miscompares++;
                    $display("FAIL bypass_hold_before: actual op1=%h required 0000000a", out_op1);
                end
                set_wb(1'b1, 5'd3, 32'd99);
                tick();
                set_wb(1'b0, 5'd0, 32'd0);
            end
            got = exp_q.pop_front();
            vectors++;
            if (obs !== got) begin
                miscompares++;
                $display("FAIL bypass%0d_bundle: actual %h required %h", k, obs, got);
            end
            $display("txn bypass%0d pc=%h op1=%h op2=%h", k, out_pc, out_op1, out_op2);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            set_wb(1'b1, 5'd3, 32'd10);
            tick();
            set_wb(1'b0, 5'd0, 32'd0);
        end
    endtask

    task automatic test_reg0;
        drive_in(32'h300, ALU_ADD, 5'd0, 5'd4, 5'd9, 1'b1, 32'd0);
        exp_q.push_back(mk(32'h300, ALU_ADD, 32'd0, 32'd20, 32'd0, 5'd9));
        set_wb(1'b1, 5'd0, 32'd55);
        tick();
        in_valid = 1'b0;
        tick();
        set_wb(1'b0, 5'd0, 32'd0);
        got = exp_q.pop_front();
        vectors++;
        if (out_valid !== 1'b1 || obs !== got) begin
            miscompares++;
            $display("FAIL reg0_bundle: actual v=%b %h required v=1 %h", out_valid, obs, got);
        end
        $display("txn reg0 pc=%h op1=%h op2=%h", out_pc, out_op1, out_op2);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        drive_in(32'h304, ALU_ADDI, 5'd3, 5'd4, 5'd10, 1'b0, 32'hffff_fff9);
        exp_q.push_back(mk(32'h304, ALU_ADDI, 32'd10, 32'd0, 32'hffff_fff9, 5'd10));
        tick();
        in_valid = 1'b0;
        set_wb(1'b1, 5'd4, 32'd77);
        tick();
        set_wb(1'b0, 5'd0, 32'd0);
        got = exp_q.pop_front();
        vectors++;
        if (out_valid !== 1'b1 || obs !== got) begin
            miscompares++;
            $display("FAIL addi_bundle: actual v=%b %h required v=1 %h", out_valid, obs, got);
        end
        $display("txn addi pc=%h op1=%h op2=%h imm=%h", out_pc, out_op1, out_op2, out_imm);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        set_wb(1'b1, 5'd4, 32'd20);
        tick();
        set_wb(1'b0, 5'd0, 32'd0);
    endtask

    task automatic test_back_to_back;
        drive_in(32'h400, ALU_XOR, 5'd5, 5'd6, 5'd11, 1'b1, 32'h123);
        exp_q.push_back(mk(32'h400, ALU_XOR, 32'h55aa, 32'd7, 32'h123, 5'd11));
        tick();
        in_valid = 1'b0;
        tick();
        drive_in(32'h404, ALU_OR, 5'd7, 5'd5, 5'd12, 1'b1, 32'h456);
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || obs !== exp_q[0]) begin
                miscompares++;
                $display("FAIL bp_hold%0d: actual v=%b r=%b %h required v=1 r=0 %h",
                         i, out_valid, in_ready, obs, exp_q[0]);
            end
            tick();
        end
        got = exp_q.pop_front();
        vectors++;
        if (obs !== got) begin
            miscompares++;
            $display("FAIL bp_first_bundle: actual %h required %h", obs, got);
        end
        $display("txn bp_first pc=%h op1=%h op2=%h", out_pc, out_op1, out_op2);
        exp_q.push_back(mk(32'h404, ALU_OR, 32'hdeadbeef, 32'h55aa, 32'h456, 5'd12));
        out_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_ready_on_hs: actual %b required 1", in_ready);
        end
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_gap: actual v=%b r=%b required 0 0", out_valid, in_ready);
        end
        tick();
        got = exp_q.pop_front();
        vectors++;
        if (out_valid !== 1'b1 || obs !== got) begin
            miscompares++;
            $display("FAIL b2b_second: actual v=%b %h required v=1 %h", out_valid, obs, got);
        end
        $display("txn b2b_second pc=%h op1=%h op2=%h", out_pc, out_op1, out_op2);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        for (int ph = 0; ph < 2; ph++) begin
            drive_in(32'h500 + 32'(ph * 16), ALU_AND, 5'd3, 5'd4, 5'd13, 1'b1, 32'h77);
            tick();
            in_valid = 1'b0;
            if (ph == 1) tick();
            rst_n = 1'b0;
            #1;
            vectors++;
            if (out_valid !== 1'b0 || in_ready !== 1'b0 || obs !== '0) begin
                miscompares++;
                $display("FAIL rst_mid%0d: actual v=%b r=%b %h required 0 0 0", ph, out_valid, in_ready, obs);
            end
            tick();
            rst_n = 1'b1;
            #1;
            vectors++;
            if (in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL rst_mid%0d_release: actual ready=%b required 1", ph, in_ready);
            end
            repeat (2) tick();
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL rst_mid%0d_stale: actual valid=%b required 0", ph, out_valid);
            end
        end
        drive_in(32'h700, ALU_SLL, 5'd6, 5'd3, 5'd15, 1'b1, 32'd2);
        exp_q.push_back(mk(32'h700, ALU_SLL, 32'd7, 32'd10, 32'd2, 5'd15));
        tick();
        in_valid = 1'b0;
        tick();
        got = exp_q.pop_front();
        vectors++;
        if (out_valid !== 1'b1 || obs !== got) begin
            miscompares++;
            $display("FAIL rst_after_bundle: actual v=%b %h required v=1 %h", out_valid, obs, got);
        end
        $display("txn post_reset pc=%h op1=%h op2=%h", out_pc, out_op1, out_op2);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_pc       = '0;
        in_instr    = ALU_ADD;
        in_rs1      = '0;
        in_rs2      = '0;
        in_rd       = '0;
        in_uses_rs2 = 1'b0;
        in_imm      = '0;
        out_ready   = 1'b0;
        set_wb(1'b0, 5'd0, 32'd0);
        test_reset();
        test_basic();
        test_bypass();
        test_reg0();
        test_back_to_back();
        test_reset_mid();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: actual %0d left required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
